// File: rtl/systolic_seq_ctrl_pkg.sv
// Shared constants and state encoding for the weight-stationary systolic array sequencer.
package systolic_seq_ctrl_pkg;

  localparam int DEF_PE_ROW     = 8;
  localparam int DEF_PE_COL     = 8;
  localparam int DEF_BIT_ROW_ID = 3;
  localparam int DEF_BIT_VALID  = 1;
  localparam int DEF_BIT_ADDR   = 9;
  localparam int DEF_PE_LAT     = 1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_W   = 3'd1,
    ST_W_SETTLE = 3'd2,
    ST_STREAM   = 3'd3,
    ST_DRAIN    = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

  // Cycles needed for the last input and its psum to leave the array.
  function automatic int drain_cycles(input int pe_row, input int pe_col, input int pe_lat);
    return pe_row + pe_col + pe_row * pe_lat;
  endfunction

endpackage

// File: rtl/systolic_seq_ctrl_skew_chain.sv
// Enable+address shift register; tap k presents the input delayed by k+1 cycles.
module skew_chain #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic [WIDTH-1:0]       addr_i,
  output logic [DEPTH-1:0]       en_o,
  output logic [DEPTH*WIDTH-1:0] addr_o
);

  logic [DEPTH-1:0]            en_q;
  logic [DEPTH-1:0][WIDTH-1:0] addr_q;

  // NOTE: chain registers are reset, not merely flushed, so an abort leaves no stale enable at the array edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      en_q   <= '0;
      addr_q <= '0;
    end else begin
      en_q[0]   <= en_i;
      addr_q[0] <= addr_i;
      for (int k = 1; k < DEPTH; k++) begin
        en_q[k]   <= en_q[k-1];
        addr_q[k] <= addr_q[k-1];
      end
    end
  end

  assign en_o   = en_q;
  assign addr_o = addr_q;

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Tile sequencer: loads a weight tile, streams skewed input reads and injects skewed psum tags.
module systolic_seq_ctrl
  import systolic_seq_ctrl_pkg::*;
#(
  parameter int PE_ROW     = DEF_PE_ROW,
  parameter int PE_COL     = DEF_PE_COL,
  parameter int BIT_ROW_ID = DEF_BIT_ROW_ID,
  parameter int BIT_VALID  = DEF_BIT_VALID,
  parameter int BIT_ADDR   = DEF_BIT_ADDR,
  parameter int PE_LAT     = DEF_PE_LAT
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          i_Start,
  input  logic [BIT_ADDR-1:0]           i_Num_Vec,
  input  logic [BIT_ADDR-1:0]           i_W_Base,
  input  logic [BIT_ADDR-1:0]           i_I_Base,
  input  logic [BIT_ADDR-1:0]           i_P_Base,
  output logic                          o_Busy,
  output logic                          o_Done,
  output logic                          o_W_Rd_En,
  output logic [BIT_ADDR-1:0]           o_W_Rd_Addr,
  output logic [PE_COL-1:0]             o_EN_W,
  output logic [BIT_ROW_ID-1:0]         o_EN_ID,
  output logic [PE_ROW-1:0]             o_I_Rd_En,
  output logic [PE_ROW*BIT_ADDR-1:0]    o_I_Rd_Addr,
  output logic [PE_COL*BIT_ADDR-1:0]    o_Addr_P,
  output logic [PE_COL*BIT_VALID-1:0]   o_Valid_P
);

  localparam int ROW_W     = $clog2(PE_ROW) + 1;
  localparam int DRAIN_CYC = drain_cycles(PE_ROW, PE_COL, PE_LAT);
  localparam int DRAIN_W   = $clog2(DRAIN_CYC + 1);

  localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(PE_ROW - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYC - 1);

  state_e                state_q, state_d;
  logic [ROW_W-1:0]      row_cnt_q, row_cnt_d;
  logic [BIT_ADDR-1:0]   vec_cnt_q, vec_cnt_d;
  logic [DRAIN_W-1:0]    drain_cnt_q, drain_cnt_d;
  logic [BIT_ADDR-1:0]   num_vec_q, w_base_q, i_base_q, p_base_q;
  logic                  en_w_q;
  logic [BIT_ROW_ID-1:0] en_id_q;

  logic                  start_accept;
  logic                  stream_en;
  logic [BIT_ADDR-1:0]   stream_i_addr, stream_p_addr;

  assign start_accept = (state_q == ST_IDLE) && i_Start;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      row_cnt_q   <= '0;
      vec_cnt_q   <= '0;
      drain_cnt_q <= '0;
      num_vec_q   <= '0;
      w_base_q    <= '0;
      i_base_q    <= '0;
      p_base_q    <= '0;
      en_w_q      <= 1'b0;
      en_id_q     <= '0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      vec_cnt_q   <= vec_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      if (start_accept) begin
        num_vec_q <= i_Num_Vec;
        w_base_q  <= i_W_Base;
        i_base_q  <= i_I_Base;
        p_base_q  <= i_P_Base;
      end
      // Weight row k arrives one cycle after its read; its tag counts down from PE_ROW-1.
      en_w_q  <= (state_q == ST_LOAD_W);
      en_id_q <= (state_q == ST_LOAD_W) ? BIT_ROW_ID'(ROW_LAST - row_cnt_q) : '0;
    end
  end

  always_comb begin
    // NOTE: every _d gets its hold value first so no path can infer a latch.
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    vec_cnt_d   = vec_cnt_q;
    drain_cnt_d = drain_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_Start) begin
          state_d   = ST_LOAD_W;
          row_cnt_d = '0;
        end
      end
      ST_LOAD_W: begin
        if (row_cnt_q == ROW_LAST) begin
          state_d   = ST_W_SETTLE;
          row_cnt_d = '0;
        end else begin
          row_cnt_d = row_cnt_q + ROW_W'(1);
        end
      end
      ST_W_SETTLE: begin
        if (row_cnt_q == ROW_LAST) begin
          row_cnt_d   = '0;
          vec_cnt_d   = '0;
          drain_cnt_d = '0;
          state_d     = (num_vec_q == '0) ? ST_DRAIN : ST_STREAM;
        end else begin
          row_cnt_d = row_cnt_q + ROW_W'(1);
        end
      end
      ST_STREAM: begin
        if (vec_cnt_q == num_vec_q - BIT_ADDR'(1)) begin
          state_d = ST_DRAIN;
        end else begin
          vec_cnt_d = vec_cnt_q + BIT_ADDR'(1);
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d = ST_DONE;
        end else begin
          drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_Busy      = (state_q != ST_IDLE);
  assign o_Done      = (state_q == ST_DONE);
  assign o_W_Rd_En   = (state_q == ST_LOAD_W);
  assign o_W_Rd_Addr = o_W_Rd_En ? w_base_q + BIT_ADDR'(row_cnt_q) : '0;
  assign o_EN_W      = {PE_COL{en_w_q}};
  assign o_EN_ID     = en_id_q;

  // Addresses are zeroed when idle so the chains shift clean zeros during drain.
  assign stream_en     = (state_q == ST_STREAM);
  assign stream_i_addr = stream_en ? i_base_q + vec_cnt_q : '0;
  assign stream_p_addr = stream_en ? p_base_q + vec_cnt_q : '0;

  logic [PE_ROW-2:0]            row_en;
  logic [(PE_ROW-1)*BIT_ADDR-1:0] row_addr;

  skew_chain #(.DEPTH(PE_ROW - 1), .WIDTH(BIT_ADDR)) u_row_skew (
    .clk_i  (CLK),
    .rst_i  (RST),
    .en_i   (stream_en),
    .addr_i (stream_i_addr),
    .en_o   (row_en),
    .addr_o (row_addr)
  );

  assign o_I_Rd_En   = {row_en, stream_en};
  assign o_I_Rd_Addr = {row_addr, stream_i_addr};

  logic [PE_COL-1:0] col_en;

  // Column i needs i+1 taps: one extra cycle covers the input buffer read latency.
  skew_chain #(.DEPTH(PE_COL), .WIDTH(BIT_ADDR)) u_col_skew (
    .clk_i  (CLK),
    .rst_i  (RST),
    .en_i   (stream_en),
    .addr_i (stream_p_addr),
    .en_o   (col_en),
    .addr_o (o_Addr_P)
  );

  for (genvar i = 0; i < PE_COL; i++) begin : g_valid
    assign o_Valid_P[i*BIT_VALID +: BIT_VALID] = {BIT_VALID{col_en[i]}};
  end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Scoreboard bench for systolic_seq_ctrl on a 4x4 array: expected events queued at start, matched as they appear.
module tb_systolic_seq_ctrl;

  localparam int P  = 4;
  localparam int C  = 4;
  localparam int BA = 9;
  localparam int D  = P + C + P * 1;

  logic              CLK = 1'b0;
  logic              RST;
  logic              i_Start;
  logic [BA-1:0]     i_Num_Vec, i_W_Base, i_I_Base, i_P_Base;
  logic              o_Busy, o_Done, o_W_Rd_En;
  logic [BA-1:0]     o_W_Rd_Addr;
  logic [C-1:0]      o_EN_W;
  logic [1:0]        o_EN_ID;
  logic [P-1:0]      o_I_Rd_En;
  logic [P*BA-1:0]   o_I_Rd_Addr;
  logic [C*BA-1:0]   o_Addr_P;
  logic [C-1:0]      o_Valid_P;

  systolic_seq_ctrl #(
    .PE_ROW(P), .PE_COL(C), .BIT_ROW_ID(2), .BIT_VALID(1), .BIT_ADDR(BA), .PE_LAT(1)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .i_Start     (i_Start),
    .i_Num_Vec   (i_Num_Vec),
    .i_W_Base    (i_W_Base),
    .i_I_Base    (i_I_Base),
    .i_P_Base    (i_P_Base),
    .o_Busy      (o_Busy),
    .o_Done      (o_Done),
    .o_W_Rd_En   (o_W_Rd_En),
    .o_W_Rd_Addr (o_W_Rd_Addr),
    .o_EN_W      (o_EN_W),
    .o_EN_ID     (o_EN_ID),
    .o_I_Rd_En   (o_I_Rd_En),
    .o_I_Rd_Addr (o_I_Rd_Addr),
    .o_Addr_P    (o_Addr_P),
    .o_Valid_P   (o_Valid_P)
  );

  always #5 CLK = ~CLK;

  // Stream ids: 0 weight read, 1 EN_ID tag, 2..5 input rows, 6..9 psum columns, 10 done.
  typedef struct {
    int stream;
    int cyc;
    int val;
  } ev_t;

  ev_t exp_q[$];
  bit  busy_map [0:4095];
  int  cyc = 0;
  int  n_cmp = 0;
  int  n_err = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic observe(input int st, input logic [31:0] val, input string tag);
    int idx = -1;
    for (int k = 0; k < exp_q.size() && idx < 0; k++)
      if (exp_q[k].stream == st) idx = k;
    n_cmp++;
    assert ((idx >= 0) === 1'b1) else begin
      n_err++;
      $error("FAIL %s: unexpected event at cycle %0d value %0d, expected none", tag, cyc, val);
    end
    if (idx >= 0) begin
      check({tag, "_cycle"}, cyc, exp_q[idx].cyc);
      check({tag, "_value"}, val, exp_q[idx].val);
      exp_q.delete(idx);
    end
  endtask

  function automatic void push_ev(input int st, input int c, input int v);
    exp_q.push_back('{stream: st, cyc: c, val: v});
  endfunction

  // Start sampled at the end of cycle s; returns the expected o_Done cycle.
  function automatic int push_tile(input int s, input int wb, input int ib, input int pb, input int nv);
    int t0, done;
    for (int k = 0; k < P; k++) begin
      push_ev(0, s + 1 + k, (wb + k) % 512);
      push_ev(1, s + 2 + k, P - 1 - k);
    end
    t0 = s + 1 + 2 * P;
    for (int n = 0; n < nv; n++) begin
      for (int j = 0; j < P; j++) push_ev(2 + j, t0 + n + j, (ib + n) % 512);
      for (int i = 0; i < C; i++) push_ev(6 + i, t0 + n + i + 1, (pb + n) % 512);
    end
    done = t0 + nv + D;
    push_ev(10, done, 0);
    for (int c2 = s + 1; c2 <= done; c2++) busy_map[c2] = 1'b1;
    return done;
  endfunction

  always @(negedge CLK) begin
    if (!RST) begin
      check("busy", o_Busy, busy_map[cyc]);
      if (o_W_Rd_En) observe(0, o_W_Rd_Addr, "w_rd");
      else           check("w_addr_idle", o_W_Rd_Addr, 0);
      if (o_EN_W != '0) begin
        check("en_w", o_EN_W, 15);
        observe(1, o_EN_ID, "en_id");
      end else begin
        check("en_id_idle", o_EN_ID, 0);
      end
      for (int j = 0; j < P; j++) begin
        if (o_I_Rd_En[j]) observe(2 + j, o_I_Rd_Addr[j*BA +: BA], $sformatf("row%0d", j));
        else              check($sformatf("row%0d_idle", j), o_I_Rd_Addr[j*BA +: BA], 0);
      end
      for (int i = 0; i < C; i++) begin
        if (o_Valid_P[i]) observe(6 + i, o_Addr_P[i*BA +: BA], $sformatf("col%0d", i));
        else              check($sformatf("col%0d_idle", i), o_Addr_P[i*BA +: BA], 0);
      end
      if (o_Done) observe(10, 0, "done");
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},   o_Busy, 0);
    check({tag, "_done"},   o_Done, 0);
    check({tag, "_w_en"},   o_W_Rd_En, 0);
    check({tag, "_w_addr"}, o_W_Rd_Addr, 0);
    check({tag, "_en_w"},   o_EN_W, 0);
    check({tag, "_en_id"},  o_EN_ID, 0);
    check({tag, "_i_en"},   o_I_Rd_En, 0);
    check({tag, "_i_addr"}, {31'd0, |o_I_Rd_Addr}, 0);
    check({tag, "_p_addr"}, {31'd0, |o_Addr_P}, 0);
    check({tag, "_p_val"},  o_Valid_P, 0);
  endtask

  task automatic step_to(input int c);
    while (cyc < c) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic start_tile(input int wb, input int ib, input int pb, input int nv,
                            output int s, output int done);
    i_W_Base  = BA'(wb);
    i_I_Base  = BA'(ib);
    i_P_Base  = BA'(pb);
    i_Num_Vec = BA'(nv);
    i_Start   = 1'b1;
    s         = cyc;
    done      = push_tile(s, wb, ib, pb, nv);
    @(posedge CLK);
    #1;
    i_Start = 1'b0;
  endtask

  int s_a, d_a, s_b, d_b, s_c, d_c, s_1, d_1, d_2;

  initial begin
    RST = 1'b1;
    i_Start = 1'b0;
    i_Num_Vec = '0;
    i_W_Base = '0;
    i_I_Base = '0;
    i_P_Base = '0;
    repeat (3) @(negedge CLK);
    check_all_zero("reset");
    @(posedge CLK);
    #1;
    RST = 1'b0;
    step_to(cyc + 2);

    // Weight load, 3-vector stream, skewed psum tags.
    start_tile(16, 100, 200, 3, s_a, d_a);
    step_to(d_a + 3);

    // Empty stream: load, settle and drain only.
    start_tile(40, 7, 9, 0, s_b, d_b);
    step_to(d_b + 3);

    // Abort during STREAM (vector 2 is on row 0).
    start_tile(0, 50, 60, 6, s_c, d_c);
    step_to(s_c + 1 + 2 * P + 2);
    RST = 1'b1;
    exp_q.delete();
    for (int k = cyc; k < 4096; k++) busy_map[k] = 1'b0;
    @(negedge CLK);
    check_all_zero("abort");
    @(posedge CLK);
    #1;
    RST = 1'b0;
    step_to(cyc + 5);

    // Start held high: ignored while busy, back-to-back tile after o_Done, addresses wrap.
    i_W_Base  = 9'd3;
    i_I_Base  = 9'd510;
    i_P_Base  = 9'd508;
    i_Num_Vec = 9'd4;
    i_Start   = 1'b1;
    s_1 = cyc;
    d_1 = push_tile(s_1, 3, 510, 508, 4);
    d_2 = push_tile(d_1 + 1, 3, 510, 508, 4);
    @(posedge CLK);
    #1;
    i_W_Base  = 9'd77;
    i_I_Base  = 9'd5;
    i_P_Base  = 9'd6;
    i_Num_Vec = 9'd9;
    step_to(d_1);
    i_W_Base  = 9'd3;
    i_I_Base  = 9'd510;
    i_P_Base  = 9'd508;
    i_Num_Vec = 9'd4;
    step_to(d_2);
    i_Start = 1'b0;
    step_to(d_2 + 4);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
